// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter: FSM states,
// requester IDs, the opcode encodings this port serves, and the reset NOP.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam logic [6:0] LD    = 7'b000_0011;
    localparam logic [6:0] SD    = 7'b010_0011;
    localparam logic [6:0] ALUop = 7'b011_0011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // The port is 64 bits wide; instructions are 32, picked by byte address bit 2.
    function automatic logic [31:0] fetch_half(input logic [63:0] word, input logic upper);
        return upper ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Fetch/data priority selection with a bounded starvation counter: data wins
// unless fetch has been passed over STARVE_MAX times in a row.
module mem_arb_prio #(
    parameter int STARVE_MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant_en,
    output logic grant_id
);
    import mem_port_arbiter_pkg::*;

    logic [2:0] starve_cnt;
    logic       fetch_turn;

    // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
    always_comb begin
        fetch_turn = if_req && (!dm_req || starve_cnt == 3'(STARVE_MAX));
        grant_id   = fetch_turn ? REQ_IF : REQ_DM;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_en) begin
            if (fetch_turn || !if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 3'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage loads/stores;
// one access in flight, IDLE -> ACCESS (MEM_LAT cycles) -> RESP.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ack,
    output logic [63:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);
    import mem_port_arbiter_pkg::*;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] lat_cnt;
    logic       gnt_q;
    logic       we_q;
    logic       grant_en;
    logic       grant_id;

    assign grant_en = (state == IDLE) && (if_req || dm_req);

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clock   (clock),
        .reset   (reset),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .grant_en(grant_en),
        .grant_id(grant_id)
    );

    // The requester may drop its inputs once granted; mem_* only ever reflect the latched copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            gnt_q     <= REQ_IF;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= NOP;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        state   <= ACCESS;
                        busy    <= 1'b1;
                        mem_en  <= 1'b1;
                        lat_cnt <= '0;
                        gnt_q   <= grant_id;
                        if (grant_id == REQ_DM) begin
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            we_q      <= dm_we;
                            mem_we    <= dm_we;
                        end else begin
                            mem_addr <= if_addr;
                            we_q     <= 1'b0;
                            mem_we   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_cnt == LAT_LAST) begin
                        state   <= RESP;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        lat_cnt <= '0;
                        if (gnt_q == REQ_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= fetch_half(mem_rdata, mem_addr[2]);
                        end else begin
                            dm_ack <= 1'b1;
                            if (!we_q) begin
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: the stimulus side predicts each grant from the arbitration
// rules and queues the expected access; a negedge monitor compares the port.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_ack;
    logic [63:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        busy;

    mem_port_arbiter #(
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          active;
        bit          granted;
        bit          dropped;
        int          ack_cyc;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } rq_t;

    typedef struct {
        int          g;
        int          ack;
        logic        id;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [31:0] if_exp;
        logic [63:0] dm_exp;
    } exp_t;

    rq_t         rq[2];
    exp_t        exp_q[$];
    logic        ack_log[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          scnt = 0;
    int          free_at = 0;
    int          last_cyc = -1;
    logic [63:0] last_word = '0;
    logic [63:0] mdl_dm = '0;
    bit          rand_mode = 0;
    bit          sat_mode = 0;
    bit          drop_all = 0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Memory contents: a fixed word at 0x4, otherwise a scramble of the address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h4) return 64'h00B5_0533_0000_0013;
        return {a[31:0] ^ 32'h9E37_79B9, a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF};
    endfunction

    task automatic new_req(input int p, input logic [63:0] a, input bit we, input logic [63:0] wd);
        rq[p].active  = 1;
        rq[p].granted = 0;
        rq[p].dropped = 0;
        rq[p].ack_cyc = 0;
        rq[p].we      = (p == 1) ? we : 1'b0;
        rq[p].addr    = a;
        rq[p].wdata   = wd;
    endtask

    // Requester behaviour for the current cycle; inputs go to junk once granted.
    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (rq[p].active && rq[p].granted && cyc > rq[p].ack_cyc) rq[p].active = 0;
            if (!rq[p].active && (sat_mode || (rand_mode && $urandom_range(0, 3) == 0)))
                new_req(p, {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom});
        end
        if_req   = rq[0].active && !rq[0].dropped;
        if_addr  = (rq[0].active && !rq[0].granted) ? rq[0].addr : {$urandom, $urandom};
        dm_req   = rq[1].active && !rq[1].dropped;
        dm_addr  = (rq[1].active && !rq[1].granted) ? rq[1].addr : {$urandom, $urandom};
        dm_wdata = (rq[1].active && !rq[1].granted) ? rq[1].wdata : {$urandom, $urandom};
        dm_we    = (rq[1].active && !rq[1].granted) ? rq[1].we : 1'($urandom_range(0, 1));
        mem_rdata = (cyc == last_cyc) ? last_word : {$urandom, $urandom};
    endtask

    // Reference model, evaluated with the inputs that were present during cycle cyc.
    task automatic model();
        int          p;
        bit          fetch_turn;
        logic [63:0] w;
        exp_t        e;
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].ack > cyc) void'(exp_q.pop_back());
            for (int k = 0; k < 2; k++) begin
                if (rq[k].granted && rq[k].ack_cyc > cyc) begin
                    rq[k].granted = 0;
                    rq[k].dropped = 0;
                end
            end
            scnt     = 0;
            free_at  = cyc + 1;
            mdl_dm   = '0;
            last_cyc = -1;
        end else if (cyc >= free_at && (if_req || dm_req)) begin
            fetch_turn = if_req && (!dm_req || scnt == STARVE_MAX);
            p = fetch_turn ? 0 : 1;
            if (fetch_turn || !if_req) scnt = 0;
            else if (scnt < STARVE_MAX) scnt = scnt + 1;
            w        = mem_word(rq[p].addr);
            e.g      = cyc;
            e.ack    = cyc + MEM_LAT + 1;
            e.id     = fetch_turn ? REQ_IF : REQ_DM;
            e.we     = rq[p].we;
            e.addr   = rq[p].addr;
            e.wdata  = rq[p].wdata;
            e.if_exp = rq[p].addr[2] ? w[63:32] : w[31:0];
            e.dm_exp = rq[p].we ? mdl_dm : w;
            if (p == 1 && !rq[p].we) mdl_dm = w;
            exp_q.push_back(e);
            rq[p].granted = 1;
            rq[p].ack_cyc = e.ack;
            rq[p].dropped = drop_all || (rand_mode && $urandom_range(0, 2) == 0);
            free_at   = cyc + MEM_LAT + 2;
            last_cyc  = cyc + MEM_LAT;
            last_word = w;
        end
    endtask

    task automatic finish_cycle();
        @(posedge clock);
        model();
        cyc++;
        #1;
    endtask

    task automatic step();
        drive();
        finish_cycle();
    endtask

    task automatic wait_idle(input int max);
        int i = 0;
        while ((rq[0].active || rq[1].active) && i < max) begin
            step();
            i++;
        end
        if (rq[0].active || rq[1].active) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle cycle %0d: requests still open after %0d cycles, want none", cyc, max);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   in_acc;
        bit   at_ack;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                in_acc = 0;
                at_ack = 0;
                if (exp_q.size() > 0) begin
                    e      = exp_q[0];
                    in_acc = (cyc > e.g) && (cyc <= e.g + MEM_LAT);
                    at_ack = (cyc == e.ack);
                end
                check("mem_en", 64'(mem_en), 64'(in_acc));
                check("mem_we", 64'(mem_we), 64'(in_acc && e.we));
                check("busy", 64'(busy), 64'(in_acc || at_ack));
                check("if_ack", 64'(if_ack), 64'(at_ack && e.id == REQ_IF));
                check("dm_ack", 64'(dm_ack), 64'(at_ack && e.id == REQ_DM));
                if (in_acc) begin
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                if (at_ack) begin
                    if (e.id == REQ_IF) check("if_rdata", 64'(if_rdata), 64'(e.if_exp));
                    else check("dm_rdata", dm_rdata, e.dm_exp);
                    void'(exp_q.pop_front());
                end
                if (if_ack) ack_log.push_back(REQ_IF);
                if (dm_ack) ack_log.push_back(REQ_DM);
            end
        end
    end

    initial begin : stimulus
        for (int p = 0; p < 2; p++) new_req(p, '0, 1'b0, '0);
        rq[0].active = 0;
        rq[1].active = 0;

        reset = 1;
        step();
        mon_en = 1;
        drive();
        @(negedge clock);
        check("rst_if_rdata", 64'(if_rdata), 64'(NOP));
        check("rst_dm_rdata", dm_rdata, 64'h0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        finish_cycle();
        step();
        reset = 0;

        // Single fetch from 0x4: upper half of the word.
        new_req(0, 64'h4, 1'b0, '0);
        wait_idle(20);
        drive();
        @(negedge clock);
        check("fetch_word", 64'(if_rdata), 64'h0000_0000_00B5_0533);
        finish_cycle();

        // Store leaves dm_rdata at its reset value.
        new_req(1, 64'h40, 1'b1, 64'h1234);
        wait_idle(20);
        drive();
        @(negedge clock);
        check("store_keeps_rdata", dm_rdata, 64'h0);
        finish_cycle();

        // Both requesters drop req right after their grant; both still complete.
        drop_all = 1;
        new_req(1, 64'h0000_0001_0000_0107, 1'b0, '0);
        new_req(0, 64'h0000_0000_0000_2002, 1'b0, '0);
        wait_idle(40);
        drop_all = 0;

        // Reset during the second ACCESS cycle of a load, then the held request completes.
        new_req(1, 64'h0000_0000_0000_1238, 1'b0, '0);
        for (int i = 0; i < 20 && !rq[1].granted; i++) step();
        step();
        reset = 1;
        step();
        reset = 0;
        drive();
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_mem_en", 64'(mem_en), 64'h0);
        check("abort_dm_ack", 64'(dm_ack), 64'h0);
        finish_cycle();
        wait_idle(20);

        // Both requesters held high continuously from a fresh reset.
        rq[0].active = 0;
        rq[1].active = 0;
        sat_mode = 1;
        reset = 1;
        step();
        reset = 0;
        ack_log.delete();
        for (int i = 0; i < 200 && ack_log.size() < 8; i++) step();
        if (ack_log.size() < 8) begin
            n_tests++;
            n_fail++;
            $display("FAIL sat_order cycle %0d: got %0d acks, want 8", cyc, ack_log.size());
        end else begin
            for (int k = 0; k < 8; k++)
                check("sat_order", 64'(ack_log[k]), 64'((k % 4 == 3) ? REQ_IF : REQ_DM));
        end
        sat_mode = 0;
        wait_idle(40);

        // Random traffic with occasional resets.
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 0;
        rand_mode = 0;
        wait_idle(100);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
